id_reg_file_sb: RTL and testbench

//  Decode-stage integer register file; the consumer end of the write-back interface.

---
 rtl/id_reg_file_sb.sv | 77 +++++++
 tb/tb_id_reg_file_sb.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/id_reg_file_sb.sv
// id_reg_file_sb: decode-stage register file with write-back bypass and a
// per-register pending-write scoreboard that drives the decode stall.
module id_reg_file_sb #(
    parameter int XLEN     = 32,
    parameter int NUM_REGS = 32,
    parameter int ADDR_W   = 5,
    parameter int CNT_W    = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] rs1_addr,
    input  logic [ADDR_W-1:0] rs2_addr,
    input  logic              rs1_used,
    input  logic              rs2_used,
    output logic [XLEN-1:0]   rs1_data,
    output logic [XLEN-1:0]   rs2_data,
    input  logic [XLEN-1:0]   write_data_wb_id,
    input  logic [ADDR_W-1:0] write_reg_wb_id,
    input  logic              ctrl_write_reg_wb_id,
    input  logic              issue_valid,
    input  logic              issue_we,
    input  logic [ADDR_W-1:0] issue_rd,
    output logic              stall_id,
    output logic              sb_error
);

    logic [XLEN-1:0]  regs [NUM_REGS];
    logic [CNT_W-1:0] cnt  [NUM_REGS];
    logic inc, dec, same, haz1, haz2, ovf, unf;

    // A stalled instruction never leaves ID, so its issue request is dropped.
    assign inc  = issue_valid && !stall_id && issue_we && issue_rd != '0;
    assign dec  = ctrl_write_reg_wb_id && write_reg_wb_id != '0;
    assign same = inc && dec && issue_rd == write_reg_wb_id;

    assign rs1_data = (rst || rs1_addr == '0) ? '0 :
                      (dec && write_reg_wb_id == rs1_addr) ? write_data_wb_id : regs[rs1_addr];
    assign rs2_data = (rst || rs2_addr == '0) ? '0 :
                      (dec && write_reg_wb_id == rs2_addr) ? write_data_wb_id : regs[rs2_addr];

    // A single outstanding producer that is writing back this cycle is covered by the bypass.
    assign haz1 = rs1_used && rs1_addr != '0 && (cnt[rs1_addr] >= CNT_W'(2) ||
                  (cnt[rs1_addr] == CNT_W'(1) && !(dec && write_reg_wb_id == rs1_addr)));
    assign haz2 = rs2_used && rs2_addr != '0 && (cnt[rs2_addr] >= CNT_W'(2) ||
                  (cnt[rs2_addr] == CNT_W'(1) && !(dec && write_reg_wb_id == rs2_addr)));
    assign stall_id = haz1 | haz2;

    assign ovf = inc && !same && cnt[issue_rd] == '1;
    assign unf = dec && !same && cnt[write_reg_wb_id] == '0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int r = 0; r < NUM_REGS; r++) regs[r] <= '0;
        end else if (dec) begin
            regs[write_reg_wb_id] <= write_data_wb_id;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int r = 0; r < NUM_REGS; r++) cnt[r] <= '0;
        end else begin
            for (int r = 1; r < NUM_REGS; r++) begin
                if (inc && issue_rd == ADDR_W'(r) && !same && cnt[r] != '1)
                    cnt[r] <= cnt[r] + 1'b1;
                else if (dec && write_reg_wb_id == ADDR_W'(r) && !same && cnt[r] != '0)
                    cnt[r] <= cnt[r] - 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) sb_error <= 1'b0;
        else if (ovf || unf) sb_error <= 1'b1;
    end

endmodule

// File: tb/tb_id_reg_file_sb.sv
// tb_id_reg_file_sb: directed checks of reads, bypass, scoreboard stall and error flag.
module tb_id_reg_file_sb;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [4:0]  rs1_addr = '0, rs2_addr = '0;
    logic        rs1_used = 1'b0, rs2_used = 1'b0;
    logic [31:0] rs1_data, rs2_data;
    logic [31:0] write_data_wb_id = '0;
    logic [4:0]  write_reg_wb_id = '0;
    logic        ctrl_write_reg_wb_id = 1'b0;
    logic        issue_valid = 1'b0, issue_we = 1'b0;
    logic [4:0]  issue_rd = '0;
    logic        stall_id, sb_error;
    int vec = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    id_reg_file_sb dut (
        .clk(clk), .rst(rst),
        .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
        .rs1_used(rs1_used), .rs2_used(rs2_used),
        .rs1_data(rs1_data), .rs2_data(rs2_data),
        .write_data_wb_id(write_data_wb_id), .write_reg_wb_id(write_reg_wb_id),
        .ctrl_write_reg_wb_id(ctrl_write_reg_wb_id),
        .issue_valid(issue_valid), .issue_we(issue_we), .issue_rd(issue_rd),
        .stall_id(stall_id), .sb_error(sb_error)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [4:0] rd);
        issue_valid = 1'b1; issue_we = 1'b1; issue_rd = rd;
        tick();
        issue_valid = 1'b0; issue_we = 1'b0; issue_rd = '0;
    endtask

    task automatic wb_set(input logic [4:0] r, input logic [31:0] d);
        ctrl_write_reg_wb_id = 1'b1; write_reg_wb_id = r; write_data_wb_id = d;
        #1;
    endtask

    task automatic wb_clr();
        ctrl_write_reg_wb_id = 1'b0; write_reg_wb_id = '0; write_data_wb_id = '0;
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; rs1_addr = 5'd5; rs2_addr = 5'd31;
        #1;
        vec++; if (rs1_data !== 32'h0) begin miscompares++; $display("FAIL reset_rs1 got %h exp %h", rs1_data, 32'h0); end
        vec++; if (rs2_data !== 32'h0) begin miscompares++; $display("FAIL reset_rs2 got %h exp %h", rs2_data, 32'h0); end
        vec++; if (stall_id !== 1'b0) begin miscompares++; $display("FAIL reset_stall got %b exp 0", stall_id); end
        vec++; if (sb_error !== 1'b0) begin miscompares++; $display("FAIL reset_err got %b exp 0", sb_error); end
        tick();
        rst = 1'b0;
        tick();
    endtask

    task automatic test_write_read();
        issue(5'd5);
        wb_set(5'd5, 32'hDEADBEEF);
        tick();
        wb_clr();
        rs1_addr = 5'd5;
        #1;
        vec++; if (rs1_data !== 32'hDEADBEEF) begin miscompares++; $display("FAIL wr_rd_x5 got %h exp %h", rs1_data, 32'hDEADBEEF); end
        wb_set(5'd0, 32'h1234);
        tick();
        wb_clr();
        rs2_addr = 5'd0;
        #1;
        vec++; if (rs2_data !== 32'h0) begin miscompares++; $display("FAIL wr_rd_x0 got %h exp %h", rs2_data, 32'h0); end
        vec++; if (sb_error !== 1'b0) begin miscompares++; $display("FAIL wr_rd_err got %b exp 0", sb_error); end
    endtask

    task automatic test_bypass();
        issue(5'd7);
        rs2_addr = 5'd7;
        #1;
        vec++; if (rs2_data !== 32'h0) begin miscompares++; $display("FAIL byp_before got %h exp %h", rs2_data, 32'h0); end
        wb_set(5'd7, 32'hA5A5A5A5);
        vec++; if (rs2_data !== 32'hA5A5A5A5) begin miscompares++; $display("FAIL byp_same got %h exp %h", rs2_data, 32'hA5A5A5A5); end
        tick();
        wb_clr();
        vec++; if (rs2_data !== 32'hA5A5A5A5) begin miscompares++; $display("FAIL byp_after got %h exp %h", rs2_data, 32'hA5A5A5A5); end
    endtask

    task automatic test_stall();
        issue(5'd3);
        rs1_addr = 5'd3; rs1_used = 1'b1;
        #1;
        vec++; if (stall_id !== 1'b1) begin miscompares++; $display("FAIL stall_c0 got %b exp 1", stall_id); end
        tick();
        vec++; if (stall_id !== 1'b1) begin miscompares++; $display("FAIL stall_c1 got %b exp 1", stall_id); end
        rs1_used = 1'b0;
        #1;
        vec++; if (stall_id !== 1'b0) begin miscompares++; $display("FAIL stall_unused got %b exp 0", stall_id); end
        rs1_used = 1'b1;
        wb_set(5'd3, 32'h33);
        vec++; if (stall_id !== 1'b0) begin miscompares++; $display("FAIL stall_wb got %b exp 0", stall_id); end
        vec++; if (rs1_data !== 32'h33) begin miscompares++; $display("FAIL stall_byp got %h exp %h", rs1_data, 32'h33); end
        tick();
        wb_clr();
        vec++; if (stall_id !== 1'b0) begin miscompares++; $display("FAIL stall_done got %b exp 0", stall_id); end
        rs1_used = 1'b0;
    endtask

    task automatic test_double_producer();
        issue(5'd4);
        issue(5'd4);
        rs2_addr = 5'd4; rs2_used = 1'b1;
        #1;
        vec++; if (stall_id !== 1'b1) begin miscompares++; $display("FAIL dbl_cnt2 got %b exp 1", stall_id); end
        wb_set(5'd4, 32'h44);
        vec++; if (stall_id !== 1'b1) begin miscompares++; $display("FAIL dbl_wb1 got %b exp 1", stall_id); end
        tick();
        wb_clr();
        vec++; if (stall_id !== 1'b1) begin miscompares++; $display("FAIL dbl_cnt1 got %b exp 1", stall_id); end
        wb_set(5'd4, 32'h45);
        vec++; if (stall_id !== 1'b0) begin miscompares++; $display("FAIL dbl_wb2 got %b exp 0", stall_id); end
        tick();
        wb_clr();
        vec++; if (stall_id !== 1'b0) begin miscompares++; $display("FAIL dbl_cnt0 got %b exp 0", stall_id); end
        vec++; if (rs2_data !== 32'h45) begin miscompares++; $display("FAIL dbl_data got %h exp %h", rs2_data, 32'h45); end
        rs2_used = 1'b0;
        issue(5'd4);
        issue_valid = 1'b1; issue_we = 1'b1; issue_rd = 5'd4;
        wb_set(5'd4, 32'h46);
        tick();
        issue_valid = 1'b0; issue_we = 1'b0; issue_rd = '0;
        wb_clr();
        rs2_used = 1'b1;
        #1;
        vec++; if (stall_id !== 1'b1) begin miscompares++; $display("FAIL same_cyc_cnt1 got %b exp 1", stall_id); end
        wb_set(5'd4, 32'h47);
        tick();
        wb_clr();
        vec++; if (stall_id !== 1'b0) begin miscompares++; $display("FAIL same_cyc_cnt0 got %b exp 0", stall_id); end
        vec++; if (sb_error !== 1'b0) begin miscompares++; $display("FAIL dbl_err got %b exp 0", sb_error); end
        rs2_used = 1'b0;
    endtask

    task automatic test_errors();
        issue(5'd9);
        issue(5'd9);
        issue(5'd9);
        vec++; if (sb_error !== 1'b0) begin miscompares++; $display("FAIL err_cnt3 got %b exp 0", sb_error); end
        issue(5'd9);
        vec++; if (sb_error !== 1'b1) begin miscompares++; $display("FAIL err_ovf got %b exp 1", sb_error); end
        rs1_addr = 5'd9; rs1_used = 1'b1;
        wb_set(5'd9, 32'h91);
        tick();
        wb_set(5'd9, 32'h92);
        tick();
        wb_clr();
        vec++; if (stall_id !== 1'b1) begin miscompares++; $display("FAIL err_hold_cnt1 got %b exp 1", stall_id); end
        wb_set(5'd9, 32'h93);
        tick();
        wb_clr();
        vec++; if (stall_id !== 1'b0) begin miscompares++; $display("FAIL err_drained got %b exp 0", stall_id); end
        rs1_used = 1'b0;
        vec++; if (sb_error !== 1'b1) begin miscompares++; $display("FAIL err_sticky got %b exp 1", sb_error); end
        rst = 1'b1; rs1_addr = 5'd5;
        #1;
        vec++; if (rs1_data !== 32'h0) begin miscompares++; $display("FAIL err_rst_rd got %h exp %h", rs1_data, 32'h0); end
        vec++; if (sb_error !== 1'b0) begin miscompares++; $display("FAIL err_rst_clr got %b exp 0", sb_error); end
        tick();
        rst = 1'b0;
        tick();
        wb_set(5'd10, 32'hA0);
        vec++; if (sb_error !== 1'b0) begin miscompares++; $display("FAIL err_unf_pre got %b exp 0", sb_error); end
        tick();
        wb_clr();
        rs2_addr = 5'd10;
        #1;
        vec++; if (sb_error !== 1'b1) begin miscompares++; $display("FAIL err_unf got %b exp 1", sb_error); end
        vec++; if (rs2_data !== 32'hA0) begin miscompares++; $display("FAIL err_unf_wr got %h exp %h", rs2_data, 32'hA0); end
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_bypass();
        test_stall();
        test_double_producer();
        test_errors();
        $display("== %0d vectors applied, %0d miscompares ==", vec, miscompares);
        $finish;
    end

endmodule
